tl_arb_2m1s: RTL and testbench
==============================

// Module: tl_arb_2m1s
// PURPOSE
//  Two-master to one-slave TileLink-UH arbiter placed directly upstream of the 128-bit TL memory slave.
//  Merges instruction-side (m0) and data-side (m1) Get/PutFullData traffic onto one slave port.
//  One transaction outstanding at a time. D responses route to the owning master by internal ownership, not d_source.
// PARAMETERS
//  DW     128  A/D data width; beat = DW/8 = 16 bytes
//  AW     32   address width
//  CNT_W  8    beat-counter width
// PORTS  (m0_*, m1_* = master side, s_* = slave side; a_* payloads: in on m*, out on s; d_* payloads: in on s, out on m*)
//  clk          in   1     clock
//  rst          in   1     async reset, active high
//  *_a_opcode   -    3     0=PutFullData, 4=Get
//  *_a_param    -    3     passed through
//  *_a_size     -    8     log2 bytes
//  *_a_source   -    3     passed through unchanged
//  *_a_address  -    AW    byte address
//  *_a_mask     -    DW/8  byte mask
//  *_a_data     -    DW    write beat
//  *_a_corrupt  -    1     passed through
//  *_a_valid / *_a_ready  -  1  A handshake (ready flows m<-s)
//  *_d_opcode   -    3     0=AccessAck, 1=AccessAckData
//  *_d_param    -    2     passed through
//  *_d_size     -    8     passed through
//  *_d_source / *_d_sink  -  3  passed through
//  *_d_denied / *_d_corrupt  -  1  passed through
//  *_d_data     -    DW    read beat
//  *_d_valid / *_d_ready  -  1  D handshake (ready flows m->s)
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=m0, rr_ptr=m0, a_left=d_left=0. All valids/readies driven low except IDLE grant logic.
//  beats(size) = (size<=4) ? 1 : 1<<(min(size,11)-4). Sizes >11 saturate to 128 beats.
//  IDLE: combinational grant. Only requester wins. Both requesting: rr_ptr wins. s_a_* muxed from grantee.
//    Grantee a_ready=s_a_ready; loser a_ready=0. Zero added latency.
//  Leaving IDLE: on first A beat ack, latch owner. Put: a_left=beats-1, d_left=1. Get: a_left=0, d_left=beats.
//    rr_ptr <= ~owner. Next state is BUSY.
//  BUSY: s_a_valid = owner a_valid only while a_left!=0; non-owner a_ready=0.
//    Each A ack decrements a_left. Each D ack decrements d_left.
//    D beats are accepted while a_left!=0 (the slave may respond early).
//  D routing: owner d_valid=s_d_valid; other d_valid=0. s_d_ready=owner d_ready. D payload broadcast to both masters.
//  Completion: the D ack that makes d_left 0 while a_left==0 returns state to IDLE next cycle.
//    The next grant is evaluated in that IDLE cycle, so there is one idle bubble between transactions.
//  Unsupported opcode (not 0/4): treated as Get with beats(size) D beats; not filtered.
//  s_d_valid in IDLE (stray): s_d_ready=1, beat dropped, no master sees it.
//  Counter underflow is impossible by construction. A D ack with d_left==0 in BUSY is dropped like a stray beat.
//  Reset mid-transaction: all state cleared immediately; in-flight beats are abandoned.
// CONFIGURATION
//  TL_ARB_FIXED_PRIO_EN defined: m0 always wins simultaneous requests; rr_ptr is removed.
//  Undefined (default): round-robin as described above.
// STRUCTURE
//  Package tl_pkg: opcode localparams (PUT_FULL=0, GET=4, ACK=0, ACK_DATA=1), BEAT_BYTES=16, function beats(size).
//  Sub-module tl_beats: size -> beat count, combinational, instanced once on the muxed a_size.
//  Top holds the FSM, counters, and A/D muxes.
// TESTING
//  m0 Get size=6 addr=0x100, slave returns 4 beats -> only m0 sees 4 d_valid beats, opcode 1; state returns to IDLE.
//  m1 Put size=6, 4 beats, slave AccessAck after last beat -> m1 gets 1 AccessAck; m0 a_ready=0 throughout.
//  m0 and m1 both request Get size=4 on the same cycle, repeated 4 times -> grants alternate m0,m1,m0,m1;
//    with TL_ARB_FIXED_PRIO_EN all four go to m0 first.
//  Put size=6 with s_a_ready toggling 1/0 every cycle -> exactly 4 A beats forwarded, lock held, no interleave from m1.
//  Owner d_ready held low 5 cycles mid-read -> s_d_ready low for those cycles, no beat lost or duplicated.
//  rst pulsed during beat 2 of a Get -> state IDLE, all valids 0; a fresh m1 Get size=4 completes normally.

Source files
------------

// File: rtl/tl_arb_2m1s_pkg.sv
// rtl/tl_arb_2m1s_pkg.sv - TileLink-UH constants and beat-count helper for the 2:1 arbiter
package tl_pkg;
   localparam int DW         = 128;
   localparam int AW         = 32;
   localparam int CNT_W      = 8;
   localparam int BEAT_BYTES = DW / 8;

   localparam logic [2:0] PUT_FULL = 3'd0;
   localparam logic [2:0] GET      = 3'd4;
   localparam logic [2:0] ACK      = 3'd0;
   localparam logic [2:0] ACK_DATA = 3'd1;

   localparam logic [CNT_W-1:0] ONE_BEAT = {{(CNT_W-1){1'b0}}, 1'b1};

   // Sizes up to one beat take a single beat; sizes above 2 KiB saturate at 128 beats.
   function automatic logic [CNT_W-1:0] beats(input logic [7:0] size);
      logic [7:0] sz;
      sz = (size > 8'd11) ? 8'd11 : size;
      if (sz <= 8'd4) return ONE_BEAT;
      return ONE_BEAT << (sz - 8'd4);
   endfunction
endpackage

// File: rtl/tl_arb_2m1s_if.sv
// rtl/tl_arb_2m1s_if.sv - TileLink-UH A/D channel bundle with master/slave modports
interface tl_if;
   logic [2:0]              a_opcode;
   logic [2:0]              a_param;
   logic [7:0]              a_size;
   logic [2:0]              a_source;
   logic [tl_pkg::AW-1:0]   a_address;
   logic [tl_pkg::DW/8-1:0] a_mask;
   logic [tl_pkg::DW-1:0]   a_data;
   logic                    a_corrupt;
   logic                    a_valid;
   logic                    a_ready;
   logic [2:0]              d_opcode;
   logic [1:0]              d_param;
   logic [7:0]              d_size;
   logic [2:0]              d_source;
   logic [2:0]              d_sink;
   logic                    d_denied;
   logic                    d_corrupt;
   logic [tl_pkg::DW-1:0]   d_data;
   logic                    d_valid;
   logic                    d_ready;

   modport master (
      output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
      input  a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data, d_valid
   );
   modport slave (
      input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
      output a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data, d_valid
   );
endinterface

// File: rtl/tl_arb_2m1s_beats.sv
// rtl/tl_arb_2m1s_beats.sv - combinational size to beat-count converter
module tl_beats
   import tl_pkg::*;
(
   input  logic [7:0]       size_i,
   output logic [CNT_W-1:0] beats_o
);
   assign beats_o = beats(size_i);
endmodule

// File: rtl/tl_arb_2m1s.sv
// rtl/tl_arb_2m1s.sv - two-master to one-slave TileLink-UH arbiter, one transaction in flight
// TL_ARB_FIXED_PRIO_EN: m0 always wins simultaneous requests instead of round-robin.
module tl_arb_2m1s
   import tl_pkg::*;
(
   input logic clk,
   input logic rst,
   tl_if.slave  m0,
   tl_if.slave  m1,
   tl_if.master s
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] a_left_q, a_left_d, d_left_q, d_left_d;
   logic [CNT_W-1:0] nbeats;
   logic             sel, prio, a_en, a_fire, d_route, d_fire;

`ifdef TL_ARB_FIXED_PRIO_EN
   assign prio = 1'b0;
`else
   logic rr_ptr_q, rr_ptr_d;
   assign prio = rr_ptr_q;
`endif

   // In IDLE the grant is purely combinational so the first beat goes out with no extra latency.
   always_comb begin
      sel = owner_q;
      if (state_q == ST_IDLE) sel = (m0.a_valid && m1.a_valid) ? prio : m1.a_valid;
   end

   assign a_en        = (state_q == ST_IDLE) || (a_left_q != '0);
   assign s.a_opcode  = sel ? m1.a_opcode  : m0.a_opcode;
   assign s.a_param   = sel ? m1.a_param   : m0.a_param;
   assign s.a_size    = sel ? m1.a_size    : m0.a_size;
   assign s.a_source  = sel ? m1.a_source  : m0.a_source;
   assign s.a_address = sel ? m1.a_address : m0.a_address;
   assign s.a_mask    = sel ? m1.a_mask    : m0.a_mask;
   assign s.a_data    = sel ? m1.a_data    : m0.a_data;
   assign s.a_corrupt = sel ? m1.a_corrupt : m0.a_corrupt;
   assign s.a_valid   = a_en && (sel ? m1.a_valid : m0.a_valid);
   assign m0.a_ready  = a_en && !sel && s.a_ready;
   assign m1.a_ready  = a_en &&  sel && s.a_ready;
   assign a_fire      = s.a_valid && s.a_ready;

   tl_beats u_beats (.size_i(s.a_size), .beats_o(nbeats));

   // Beats arriving with no expected response left (including all of IDLE) are sunk here.
   assign d_route    = (state_q == ST_BUSY) && (d_left_q != '0);
   assign m0.d_valid = d_route && !owner_q && s.d_valid;
   assign m1.d_valid = d_route &&  owner_q && s.d_valid;
   assign s.d_ready  = d_route ? (owner_q ? m1.d_ready : m0.d_ready) : 1'b1;
   assign d_fire     = d_route && s.d_valid && s.d_ready;

   assign m0.d_opcode  = s.d_opcode;   assign m1.d_opcode  = s.d_opcode;
   assign m0.d_param   = s.d_param;    assign m1.d_param   = s.d_param;
   assign m0.d_size    = s.d_size;     assign m1.d_size    = s.d_size;
   assign m0.d_source  = s.d_source;   assign m1.d_source  = s.d_source;
   assign m0.d_sink    = s.d_sink;     assign m1.d_sink    = s.d_sink;
   assign m0.d_denied  = s.d_denied;   assign m1.d_denied  = s.d_denied;
   assign m0.d_corrupt = s.d_corrupt;  assign m1.d_corrupt = s.d_corrupt;
   assign m0.d_data    = s.d_data;     assign m1.d_data    = s.d_data;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      a_left_d = a_left_q;
      d_left_d = d_left_q;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      if (state_q == ST_IDLE) begin
         if (a_fire) begin
            owner_d = sel;
            state_d = ST_BUSY;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_d = ~sel;
`endif
            // Anything that is not a PutFullData is handled as a Get.
            if (s.a_opcode == PUT_FULL) begin
               a_left_d = nbeats - ONE_BEAT;
               d_left_d = ONE_BEAT;
            end else begin
               a_left_d = '0;
               d_left_d = nbeats;
            end
         end
      end else begin
         if (a_fire) a_left_d = a_left_q - ONE_BEAT;
         if (d_fire) d_left_d = d_left_q - ONE_BEAT;
         if (a_left_d == '0 && d_left_d == '0) state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         a_left_q <= '0;
         d_left_q <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
         rr_ptr_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         a_left_q <= a_left_d;
         d_left_q <= d_left_d;
`ifndef TL_ARB_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end
endmodule

// File: tb/tb_tl_arb_2m1s.sv
// tb/tb_tl_arb_2m1s.sv - directed self-checking bench for tl_arb_2m1s
module tb_tl_arb_2m1s;
   import tl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   tl_if m0_b ();
   tl_if m1_b ();
   tl_if s_b ();

   tl_arb_2m1s dut (.clk(clk), .rst(rst), .m0(m0_b), .m1(m1_b), .s(s_b));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic clear_all();
      m0_b.a_valid = 0; m0_b.a_opcode = GET; m0_b.a_param = 0; m0_b.a_size = 4; m0_b.a_source = 3'd1;
      m0_b.a_address = 0; m0_b.a_mask = '1; m0_b.a_data = 0; m0_b.a_corrupt = 0; m0_b.d_ready = 1;
      m1_b.a_valid = 0; m1_b.a_opcode = GET; m1_b.a_param = 0; m1_b.a_size = 4; m1_b.a_source = 3'd2;
      m1_b.a_address = 0; m1_b.a_mask = '1; m1_b.a_data = 0; m1_b.a_corrupt = 0; m1_b.d_ready = 1;
      s_b.a_ready = 0; s_b.d_valid = 0; s_b.d_opcode = ACK; s_b.d_param = 0; s_b.d_size = 0;
      s_b.d_source = 0; s_b.d_sink = 0; s_b.d_denied = 0; s_b.d_corrupt = 0; s_b.d_data = 0;
   endtask

   task automatic test_reset();
      clear_all();
      rst = 1'b1;
      s_b.d_valid = 1;
      repeat (2) @(posedge clk);
      samp();
      nvec++; if (s_b.a_valid !== 1'b0) begin nerr++; $display("FAIL rst_s_a_valid got %0b want 0", s_b.a_valid); end
      nvec++; if (m0_b.d_valid !== 1'b0 || m1_b.d_valid !== 1'b0) begin nerr++; $display("FAIL rst_d_valid got %0b%0b want 00", m0_b.d_valid, m1_b.d_valid); end
      nvec++; if (s_b.d_ready !== 1'b1) begin nerr++; $display("FAIL rst_s_d_ready got %0b want 1", s_b.d_ready); end
      tick();
      rst = 1'b0;
      s_b.d_valid = 0;
      tick();
   endtask

   task automatic test_get_m0();
      m0_b.a_valid = 1; m0_b.a_opcode = GET; m0_b.a_size = 6; m0_b.a_address = 32'h100;
      s_b.a_ready = 1;
      samp();
      nvec++; if (s_b.a_valid !== 1'b1 || s_b.a_address !== 32'h100) begin nerr++; $display("FAIL get_a_fwd got v=%0b addr=%0h want v=1 addr=100", s_b.a_valid, s_b.a_address); end
      nvec++; if (m0_b.a_ready !== 1'b1 || m1_b.a_ready !== 1'b0) begin nerr++; $display("FAIL get_a_ready got %0b%0b want 10", m0_b.a_ready, m1_b.a_ready); end
      tick();
      m0_b.a_valid = 0;
      for (int i = 0; i < 4; i++) begin
         s_b.d_valid = 1; s_b.d_opcode = ACK_DATA; s_b.d_data = 128'(32'h10 + i);
         samp();
         nvec++;
         if (m0_b.d_valid !== 1'b1 || m1_b.d_valid !== 1'b0 || m0_b.d_opcode !== ACK_DATA || m0_b.d_data !== 128'(32'h10 + i)) begin
            nerr++; $display("FAIL get_d_beat%0d got v=%0b%0b op=%0d data=%0h want v=10 op=1 data=%0h", i, m0_b.d_valid, m1_b.d_valid, m0_b.d_opcode, m0_b.d_data, 32'h10 + i);
         end
         tick();
      end
      s_b.d_valid = 0;
      m1_b.a_valid = 1; s_b.a_ready = 0;
      samp();
      nvec++; if (s_b.a_valid !== 1'b1 || s_b.a_source !== 3'd2) begin nerr++; $display("FAIL get_back_idle got v=%0b src=%0d want v=1 src=2", s_b.a_valid, s_b.a_source); end
      tick();
      m1_b.a_valid = 0;
   endtask

   task automatic test_put_m1();
      s_b.a_ready = 1;
      m0_b.a_valid = 1; m0_b.a_opcode = GET; m0_b.a_size = 4;
      m1_b.a_valid = 1; m1_b.a_opcode = PUT_FULL; m1_b.a_size = 6;
      for (int k = 0; k < 4; k++) begin
         m1_b.a_data = 128'(32'hA0 + k);
         samp();
         nvec++;
         if (s_b.a_valid !== 1'b1 || s_b.a_source !== 3'd2 || s_b.a_data !== 128'(32'hA0 + k) || m0_b.a_ready !== 1'b0 || m1_b.a_ready !== 1'b1) begin
            nerr++; $display("FAIL put_a_beat%0d got v=%0b src=%0d data=%0h rdy=%0b%0b want v=1 src=2 data=%0h rdy=01", k, s_b.a_valid, s_b.a_source, s_b.a_data, m0_b.a_ready, m1_b.a_ready, 32'hA0 + k);
         end
         tick();
      end
      m1_b.a_valid = 0;
      samp();
      nvec++; if (s_b.a_valid !== 1'b0 || m0_b.a_ready !== 1'b0) begin nerr++; $display("FAIL put_lock got v=%0b m0rdy=%0b want 0 0", s_b.a_valid, m0_b.a_ready); end
      tick();
      m0_b.a_valid = 0;
      s_b.d_valid = 1; s_b.d_opcode = ACK;
      samp();
      nvec++; if (m1_b.d_valid !== 1'b1 || m0_b.d_valid !== 1'b0 || m1_b.d_opcode !== ACK) begin nerr++; $display("FAIL put_ack got v=%0b%0b op=%0d want v=01 op=0", m0_b.d_valid, m1_b.d_valid, m1_b.d_opcode); end
      tick();
      samp();
      nvec++; if (m1_b.d_valid !== 1'b0 || s_b.d_ready !== 1'b1) begin nerr++; $display("FAIL put_stray_drop got v=%0b rdy=%0b want 0 1", m1_b.d_valid, s_b.d_ready); end
      tick();
      s_b.d_valid = 0;
   endtask

   task automatic test_rr();
      for (int r = 0; r < 4; r++) begin
         logic exp_m1;
`ifdef TL_ARB_FIXED_PRIO_EN
         exp_m1 = 1'b0;
`else
         exp_m1 = (r % 2) == 1;
`endif
         m0_b.a_valid = 1; m0_b.a_opcode = GET; m0_b.a_size = 4;
         m1_b.a_valid = 1; m1_b.a_opcode = GET; m1_b.a_size = 4;
         s_b.a_ready = 1;
         samp();
         nvec++; if (s_b.a_source !== (exp_m1 ? 3'd2 : 3'd1)) begin nerr++; $display("FAIL rr_grant%0d got src=%0d want %0d", r, s_b.a_source, exp_m1 ? 2 : 1); end
         tick();
         m0_b.a_valid = 0; m1_b.a_valid = 0;
         s_b.d_valid = 1; s_b.d_opcode = ACK_DATA;
         samp();
         nvec++; if (m0_b.d_valid !== !exp_m1 || m1_b.d_valid !== exp_m1) begin nerr++; $display("FAIL rr_d_route%0d got v=%0b%0b want %0b%0b", r, m0_b.d_valid, m1_b.d_valid, !exp_m1, exp_m1); end
         tick();
         s_b.d_valid = 0;
      end
   endtask

   task automatic test_put_stall();
      int   fwd;
      logic fire;
      fwd = 0;
      m0_b.a_valid = 1; m0_b.a_opcode = PUT_FULL; m0_b.a_size = 6;
      m1_b.a_valid = 1; m1_b.a_opcode = GET; m1_b.a_size = 4;
      for (int c = 0; c < 20 && fwd < 4; c++) begin
         s_b.a_ready = (c % 2) == 0;
         m0_b.a_data = 128'(32'hB0 + fwd);
         samp();
         fire = s_b.a_valid && s_b.a_ready;
         nvec++; if (m1_b.a_ready !== 1'b0) begin nerr++; $display("FAIL stall_m1_ready c%0d got %0b want 0", c, m1_b.a_ready); end
         if (fire) begin
            nvec++;
            if (s_b.a_source !== 3'd1 || s_b.a_data !== 128'(32'hB0 + fwd)) begin
               nerr++; $display("FAIL stall_beat%0d got src=%0d data=%0h want src=1 data=%0h", fwd, s_b.a_source, s_b.a_data, 32'hB0 + fwd);
            end
         end
         tick();
         if (fire) fwd++;
      end
      m0_b.a_valid = 0; s_b.a_ready = 1;
      samp();
      nvec++; if (s_b.a_valid !== 1'b0 || fwd !== 4) begin nerr++; $display("FAIL stall_count got v=%0b beats=%0d want v=0 beats=4", s_b.a_valid, fwd); end
      tick();
      m1_b.a_valid = 0;
      s_b.d_valid = 1; s_b.d_opcode = ACK;
      samp();
      nvec++; if (m0_b.d_valid !== 1'b1 || m1_b.d_valid !== 1'b0) begin nerr++; $display("FAIL stall_ack got v=%0b%0b want 10", m0_b.d_valid, m1_b.d_valid); end
      tick();
      s_b.d_valid = 0;
   endtask

   task automatic test_d_backpressure();
      int   sent, recv;
      logic s_hs, m_hs;
      sent = 0; recv = 0;
      m1_b.a_valid = 1; m1_b.a_opcode = GET; m1_b.a_size = 6; s_b.a_ready = 1;
      samp();
      nvec++; if (m1_b.a_ready !== 1'b1) begin nerr++; $display("FAIL bp_grant got %0b want 1", m1_b.a_ready); end
      tick();
      m1_b.a_valid = 0;
      s_b.d_valid = 1; s_b.d_opcode = ACK_DATA;
      for (int c = 0; c < 20 && sent < 4; c++) begin
         s_b.d_data  = 128'(32'hC0 + sent);
         m1_b.d_ready = !(c >= 1 && c <= 5);
         samp();
         s_hs = s_b.d_valid && s_b.d_ready;
         m_hs = m1_b.d_valid && m1_b.d_ready;
         nvec++; if (s_b.d_ready !== m1_b.d_ready || m1_b.d_valid !== 1'b1) begin nerr++; $display("FAIL bp_ready c%0d got rdy=%0b v=%0b want rdy=%0b v=1", c, s_b.d_ready, m1_b.d_valid, m1_b.d_ready); end
         if (m_hs) begin
            nvec++; if (m1_b.d_data !== 128'(32'hC0 + recv)) begin nerr++; $display("FAIL bp_data%0d got %0h want %0h", recv, m1_b.d_data, 32'hC0 + recv); end
         end
         tick();
         if (s_hs) sent++;
         if (m_hs) recv++;
      end
      s_b.d_valid = 0; m1_b.d_ready = 1;
      nvec++; if (recv !== 4 || sent !== 4) begin nerr++; $display("FAIL bp_count got recv=%0d sent=%0d want 4 4", recv, sent); end
      tick();
   endtask

   task automatic test_reset_mid();
      m0_b.a_valid = 1; m0_b.a_opcode = GET; m0_b.a_size = 6; s_b.a_ready = 1;
      tick();
      m0_b.a_valid = 0;
      s_b.d_valid = 1; s_b.d_opcode = ACK_DATA; s_b.d_data = 128'd1;
      tick();
      s_b.d_data = 128'd2;
      #1 rst = 1'b1;
      #1;
      nvec++; if (m0_b.d_valid !== 1'b0 || m1_b.d_valid !== 1'b0 || s_b.a_valid !== 1'b0 || s_b.d_ready !== 1'b1) begin
         nerr++; $display("FAIL rstmid_state got dv=%0b%0b av=%0b drdy=%0b want 00 0 1", m0_b.d_valid, m1_b.d_valid, s_b.a_valid, s_b.d_ready);
      end
      tick();
      rst = 1'b0; s_b.d_valid = 0;
      m1_b.a_valid = 1; m1_b.a_opcode = GET; m1_b.a_size = 4;
      samp();
      nvec++; if (m1_b.a_ready !== 1'b1 || s_b.a_source !== 3'd2) begin nerr++; $display("FAIL rstmid_regrant got rdy=%0b src=%0d want 1 2", m1_b.a_ready, s_b.a_source); end
      tick();
      m1_b.a_valid = 0; s_b.d_valid = 1;
      samp();
      nvec++; if (m1_b.d_valid !== 1'b1 || m0_b.d_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_d got v=%0b%0b want 01", m0_b.d_valid, m1_b.d_valid); end
      tick();
      s_b.d_valid = 0; s_b.a_ready = 0;
      m0_b.a_valid = 1;
      samp();
      nvec++; if (s_b.a_valid !== 1'b1 || s_b.a_source !== 3'd1) begin nerr++; $display("FAIL rstmid_idle got v=%0b src=%0d want 1 1", s_b.a_valid, s_b.a_source); end
      tick();
      m0_b.a_valid = 0;
   endtask

   initial begin
      test_reset();
      test_get_m0();
      test_put_m1();
      test_rr();
      test_put_stall();
      test_d_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
